// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arbState_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker producing a one-hot grant.
// Build option: MEM_ARB_FIXED_PRIO_EN makes requester 0 always win ties and removes the pointer.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN

    logic unusedInputs;
    assign unusedInputs = ^{clk, rst, update_i};

    // Requester 0 takes every tie; a lone request is granted as-is.
    always_comb begin
        grant_o = req_i;
        if (req_i[REQ0] && req_i[REQ1]) begin
            grant_o = 2'b00;
            grant_o[REQ0] = 1'b1;
        end
    end

`else

    logic ptr_q;
    logic ptr_d;

    // The pointer names the requester favoured on the next tie; after a grant it
    // points at the requester that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = grant_o[REQ0];
        end
    end

    // Pointer register; reset favours requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Ties are broken by the pointer; a lone request is granted as-is.
    always_comb begin
        grant_o = req_i;
        if (req_i[REQ0] && req_i[REQ1]) begin
            grant_o[REQ1] = ptr_q;
            grant_o[REQ0] = !ptr_q;
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester sequencer in front of a single-port word memory: one access at a
// time, one-cycle strobes, read data captured per requester, ack pulse to the winner.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int READ_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_addrRe,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_MemRead,
    output logic          mem_MemWrite,
    input  logic [DW-1:0] mem_read_data,
    output logic          busy
);

    localparam int CW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = (READ_LAT > 0) ? CW'(READ_LAT - 1) : '0;

    arbState_t     state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          winner_q, winner_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [1:0]    grant;
    logic          update;
    logic          capture;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({r1_req, r0_req}),
        .update_i (update),
        .grant_o  (grant)
    );

    // All state clears asynchronously, which also drops any in-flight strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            winner_q <= 1'b0;
            count_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Sequencing: latch the winner's request in IDLE, strobe memory, wait out the
    // read latency, then pulse ack. The arbiter pointer advances when a grant is
    // taken; arbitration only happens in IDLE so this matches advancing at RESP.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        winner_d = winner_q;
        count_d  = count_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        update   = 1'b0;
        capture  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant[REQ0] || grant[REQ1]) begin
                    update   = 1'b1;
                    winner_d = grant[REQ1];
                    if (grant[REQ1]) begin
                        we_d    = r1_we;
                        addr_d  = r1_addr;
                        wdata_d = r1_wdata;
                    end else begin
                        we_d    = r0_we;
                        addr_d  = r0_addr;
                        wdata_d = r0_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (READ_LAT == 0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    count_d = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (count_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            if (winner_q) begin
                rdata1_d = mem_read_data;
            end else begin
                rdata0_d = mem_read_data;
            end
        end
    end

    assign mem_addr       = addr_q;
    assign mem_addrRe     = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_MemWrite   = (state_q == ACCESS) && we_q;
    assign mem_MemRead    = ((state_q == ACCESS) || (state_q == WAIT)) && !we_q;
    assign r0_ack         = (state_q == RESP) && !winner_q;
    assign r1_ack         = (state_q == RESP) && winner_q;
    assign r0_rdata       = rdata0_q;
    assign r1_rdata       = rdata1_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a word memory model attached
// and a transaction-level reference model (memory image, per-requester rdata, tie favourite).
module tb_mem_port_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int READ_LAT = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_ack;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_ack;
    logic [DW-1:0] r1_rdata;
    logic [AW-1:0] mem_addr, mem_addrRe;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_MemRead, mem_MemWrite, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .r0_req         (r0_req),
        .r0_we          (r0_we),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r0_ack         (r0_ack),
        .r0_rdata       (r0_rdata),
        .r1_req         (r1_req),
        .r1_we          (r1_we),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r1_ack         (r1_ack),
        .r1_rdata       (r1_rdata),
        .mem_addr       (mem_addr),
        .mem_addrRe     (mem_addrRe),
        .mem_write_data (mem_write_data),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    // Memory model: writes commit on the strobe edge; read data is only valid once
    // MemRead has been held for READ_LAT edges, garbage before that.
    logic [DW-1:0] memArray [32] = '{default: '0};
    int readRun = 0;

    always @(posedge clk) begin
        if (mem_MemWrite) memArray[mem_addr] <= mem_write_data;
        if (mem_MemRead) readRun <= readRun + 1;
        else readRun <= 0;
    end

    assign mem_read_data = (mem_MemRead && readRun >= READ_LAT) ? memArray[mem_addrRe] : DW'(32'hBADC0FFE);

    // Reference model state.
    logic [DW-1:0] refMem [32] = '{default: '0};
    logic [DW-1:0] refRdata [2] = '{default: '0};
    int refFavour = 0;

    function automatic void modelComplete(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (we) refMem[a] = d;
        else refRdata[who] = refMem[a];
        refFavour = 1 - who;
    endfunction

    function automatic void modelReset();
        refRdata[0] = '0;
        refRdata[1] = '0;
        refFavour = 0;
    endfunction

    task automatic driveReq(input int idx, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (idx == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic waitIdle();
        @(negedge clk);
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wait_idle busy=%0b expected=0", busy);
        end
    endtask

    // Waits (bounded) for the next ack; counts negedges and strobe cycles on the way,
    // and drops the acked requester's req. who=-1 on timeout.
    task automatic collectAck(output int who, output int cycles, output int rdStrobes,
                              output int wrStrobes, output logic [AW-1:0] strobeAddr, output bit bothAck);
        who = -1; cycles = 0; rdStrobes = 0; wrStrobes = 0; strobeAddr = '0; bothAck = 1'b0;
        for (int n = 0; n < 50 && who < 0; n++) begin
            @(negedge clk);
            cycles++;
            if (mem_MemRead) rdStrobes++;
            if (mem_MemWrite) wrStrobes++;
            if (mem_MemRead || mem_MemWrite) strobeAddr = mem_addr;
            if (r0_ack && r1_ack) bothAck = 1'b1;
            if (r0_ack) begin
                who = 0; r0_req = 1'b0;
            end else if (r1_ack) begin
                who = 1; r1_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_MemRead, mem_MemWrite, r0_ack, r1_ack} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b expected=00000", {busy, mem_MemRead, mem_MemWrite, r0_ack, r1_ack});
        end
        checks++;
        if ({r0_rdata, r1_rdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h/%h expected=0/0", r0_rdata, r1_rdata);
        end
        checks++;
        if ({mem_addr, mem_addrRe, mem_write_data} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_membus got=%h/%h/%h expected=0", mem_addr, mem_addrRe, mem_write_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_busy got=%b expected=0", busy);
        end
    endtask

    task automatic test_write();
        int who, cyc, rs, ws;
        logic [AW-1:0] sa;
        bit both;
        waitIdle();
        driveReq(0, 1'b1, 5'd3, 32'hDEADBEEF);
        collectAck(who, cyc, rs, ws, sa, both);
        modelComplete(0, 1'b1, 5'd3, 32'hDEADBEEF);
        checks++;
        if (who !== 0) begin failures++; $display("[TB] FAIL write_winner got=%0d expected=0", who); end
        checks++;
        if (cyc + 1 !== 3) begin failures++; $display("[TB] FAIL write_latency got=%0d expected=3", cyc + 1); end
        checks++;
        if (ws !== 1 || rs !== 0) begin failures++; $display("[TB] FAIL write_strobes wr=%0d rd=%0d expected=1/0", ws, rs); end
        checks++;
        if (sa !== 5'd3) begin failures++; $display("[TB] FAIL write_addr got=%0d expected=3", sa); end
        checks++;
        if (both !== 1'b0) begin failures++; $display("[TB] FAIL write_r1_ack got=1 expected=0"); end
        @(negedge clk);
        checks++;
        if ({r0_ack, r1_ack} !== 2'b00) begin failures++; $display("[TB] FAIL write_ack_pulse got=%b expected=00", {r0_ack, r1_ack}); end
    endtask

    task automatic test_readback();
        int who, cyc, rs, ws;
        logic [AW-1:0] sa;
        bit both;
        waitIdle();
        driveReq(1, 1'b0, 5'd3, '0);
        collectAck(who, cyc, rs, ws, sa, both);
        modelComplete(1, 1'b0, 5'd3, '0);
        checks++;
        if (who !== 1) begin failures++; $display("[TB] FAIL readback_winner got=%0d expected=1", who); end
        checks++;
        if (r1_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL readback_r1_rdata got=%h expected=deadbeef", r1_rdata); end
        checks++;
        if (r0_rdata !== refRdata[0]) begin failures++; $display("[TB] FAIL readback_r0_rdata got=%h expected=%h", r0_rdata, refRdata[0]); end
    endtask

    task automatic test_contention();
        int who, cyc, rs, ws, expWho;
        logic [AW-1:0] sa;
        bit both;
        logic          opWe [2];
        logic [AW-1:0] opAddr [2];
        logic [DW-1:0] opData [2];
        waitIdle();
        opWe[0] = 1'b0; opAddr[0] = 5'd3;  opData[0] = '0;
        opWe[1] = 1'b1; opAddr[1] = 5'd9;  opData[1] = 32'hCAFE0001;
        driveReq(0, opWe[0], opAddr[0], opData[0]);
        driveReq(1, opWe[1], opAddr[1], opData[1]);
        for (int step = 0; step < 3; step++) begin
            expWho = (r0_req && r1_req) ? (FIXED ? 0 : refFavour) : (r1_req ? 1 : 0);
            collectAck(who, cyc, rs, ws, sa, both);
            checks++;
            if (who !== expWho) begin failures++; $display("[TB] FAIL tie_winner_%0d got=%0d expected=%0d", step, who, expWho); end
            modelComplete(expWho, opWe[expWho], opAddr[expWho], opData[expWho]);
            checks++;
            if (r0_rdata !== refRdata[0] || r1_rdata !== refRdata[1])
                begin failures++; $display("[TB] FAIL tie_rdata_%0d got=%h/%h expected=%h/%h", step, r0_rdata, r1_rdata, refRdata[0], refRdata[1]); end
            if (step == 0) begin
                // The first winner re-requests straight after its ack: a fresh tie.
                opWe[expWho] = 1'b0; opAddr[expWho] = 5'd9; opData[expWho] = '0;
                driveReq(expWho, opWe[expWho], opAddr[expWho], opData[expWho]);
            end
        end
    endtask

    task automatic test_read_latency();
        int who, cyc, rs, ws;
        logic [AW-1:0] sa;
        bit both;
        for (int i = 0; i < 4; i++) begin
            waitIdle();
            driveReq(0, 1'b1, AW'(i), DW'(i));
            collectAck(who, cyc, rs, ws, sa, both);
            modelComplete(0, 1'b1, AW'(i), DW'(i));
            checks++;
            if (who !== 0) begin failures++; $display("[TB] FAIL lat_write_%0d got=%0d expected=0", i, who); end
        end
        for (int i = 0; i < 4; i++) begin
            waitIdle();
            driveReq(1, 1'b0, AW'(i), '0);
            collectAck(who, cyc, rs, ws, sa, both);
            modelComplete(1, 1'b0, AW'(i), '0);
            checks++;
            if (cyc + 1 !== 3 + READ_LAT) begin failures++; $display("[TB] FAIL lat_read_latency_%0d got=%0d expected=%0d", i, cyc + 1, 3 + READ_LAT); end
            checks++;
            if (rs !== 1 + READ_LAT || ws !== 0) begin failures++; $display("[TB] FAIL lat_read_strobes_%0d rd=%0d wr=%0d expected=%0d/0", i, rs, ws, 1 + READ_LAT); end
            checks++;
            if (r1_rdata !== DW'(i) || sa !== AW'(i)) begin failures++; $display("[TB] FAIL lat_read_data_%0d got=%h@%0d expected=%h@%0d", i, r1_rdata, sa, i, i); end
        end
    endtask

    task automatic test_random();
        int who, cyc, rs, ws, expWho;
        logic [AW-1:0] sa;
        bit both;
        logic [1:0]    pend;
        logic          opWe [2];
        logic [AW-1:0] opAddr [2];
        logic [DW-1:0] opData [2];
        for (int it = 0; it < 30; it++) begin
            waitIdle();
            pend = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                opWe[k] = 1'($urandom);
                opAddr[k] = AW'($urandom);
                opData[k] = DW'($urandom);
                if (pend[k]) driveReq(k, opWe[k], opAddr[k], opData[k]);
            end
            while (pend != 2'b00) begin
                expWho = (pend == 2'b11) ? (FIXED ? 0 : refFavour) : (pend[1] ? 1 : 0);
                collectAck(who, cyc, rs, ws, sa, both);
                checks++;
                if (who !== expWho) begin failures++; $display("[TB] FAIL rand_winner_%0d got=%0d expected=%0d", it, who, expWho); end
                modelComplete(expWho, opWe[expWho], opAddr[expWho], opData[expWho]);
                checks++;
                if (r0_rdata !== refRdata[0] || r1_rdata !== refRdata[1])
                    begin failures++; $display("[TB] FAIL rand_rdata_%0d got=%h/%h expected=%h/%h", it, r0_rdata, r1_rdata, refRdata[0], refRdata[1]); end
                pend[expWho] = 1'b0;
                if (who < 0) begin
                    r0_req = 1'b0; r1_req = 1'b0; pend = 2'b00;
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        int who, cyc, rs, ws, acks;
        logic [AW-1:0] sa;
        bit both;
        waitIdle();
        driveReq(1, 1'b1, 5'd7, 32'h12345678);
        collectAck(who, cyc, rs, ws, sa, both);
        modelComplete(1, 1'b1, 5'd7, 32'h12345678);
        waitIdle();
        driveReq(0, 1'b1, 5'd7, 32'h00000055);
        @(posedge clk);
        #1;
        checks++;
        if (mem_MemWrite !== 1'b1 || mem_addr !== 5'd7) begin failures++; $display("[TB] FAIL midop_strobe got=%b@%0d expected=1@7", mem_MemWrite, mem_addr); end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_MemWrite, busy} !== 2'b00) begin failures++; $display("[TB] FAIL midop_async_drop got=%b expected=00", {mem_MemWrite, busy}); end
        checks++;
        if ({r0_rdata, r1_rdata, mem_addr, mem_write_data} !== '0) begin failures++; $display("[TB] FAIL midop_async_clear got=%h/%h/%h/%h expected=0", r0_rdata, r1_rdata, mem_addr, mem_write_data); end
        modelReset();
        acks = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) acks++;
            r0_req = 1'b0;
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin failures++; $display("[TB] FAIL midop_no_ack got=%0d expected=0", acks); end
        waitIdle();
        driveReq(1, 1'b0, 5'd7, '0);
        collectAck(who, cyc, rs, ws, sa, both);
        modelComplete(1, 1'b0, 5'd7, '0);
        checks++;
        if (who !== 1 || r1_rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL midop_readback got=%0d:%h expected=1:12345678", who, r1_rdata); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_contention();
        test_read_latency();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the 32-word Memory block (addr, addrRe, write_data, MemRead, MemWrite, read_data).
- Shares the single memory between requester 0 (e.g. datapath load/store) and requester 1 (e.g. loader/debug port).
- Issues one access at a time with one-cycle strobes, captures read data and returns an ack pulse to the winner.
- Round-robin fairness between the two requesters.

Parameters:
- AW, 5, address width (word index 0..2^AW-1)
- DW, 32, data width
- READ_LAT, 0, extra cycles after the MemRead cycle before read_data is valid (legal 0..3; 0 = combinational read)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- r0_req  in  1  requester 0 access request
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  AW  word address
- r0_wdata  in  DW  write data
- r0_ack  out  1  one-cycle completion pulse
- r0_rdata  out  DW  read result, valid when r0_ack is high, held afterwards
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as requester 0, for requester 1
- mem_addr  out  AW  to Memory addr
- mem_addrRe  out  AW  to Memory addrRe (same value as mem_addr)
- mem_write_data  out  DW  to Memory write_data
- mem_MemRead  out  1  read strobe
- mem_MemWrite  out  1  write strobe
- mem_read_data  in  DW  from Memory read_data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: state IDLE; all outputs 0, including both rdata registers and the mem_* buses; RR pointer set so requester 0 wins the first tie.
- FSM (registered): IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
- IDLE:
  - Sample r0_req/r1_req. If either is high, pick the winner and latch its we/addr/wdata into internal registers, then go to ACCESS.
  - With no request, remain in IDLE.
- ACCESS (1 cycle):
  - mem_addr = mem_addrRe = latched addr; mem_write_data = latched wdata.
  - Write: mem_MemWrite=1 for exactly this cycle; the write commits on the closing edge; go to RESP.
  - Read: mem_MemRead=1. If READ_LAT=0, capture mem_read_data into winner's rdata at the closing edge and go to RESP; otherwise go to WAIT.
- WAIT: mem_MemRead stays 1 with address held; a down-counter of width clog2(READ_LAT+1) runs for READ_LAT cycles; capture data on the last one; go to RESP.
- RESP (1 cycle): winner's ack=1; the RR pointer flips to favour the other requester; go to IDLE.
- Latency from req sampled in IDLE to ack: write 3 cycles; read 3+READ_LAT cycles. No pipelining; one outstanding transaction.
- Strobes are 0 in IDLE and RESP. mem_addr/mem_write_data hold their last latched values outside ACCESS/WAIT.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - A req still high in the cycle after ack is a new transaction.
  - Dropping req after it has been latched does not cancel: the access completes and ack still pulses.
- Simultaneous requests: the RR pointer decides; the loser waits in IDLE and is served next.
- Non-winner ack is always 0. The non-winner's rdata is unchanged.
- Reset mid-operation: all registers clear immediately. An in-flight strobe drops asynchronously, no ack is issued, and the transaction is lost; the requester must re-request.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests; the RR pointer is not implemented.
- Undefined (default): round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - the state typedef (IDLE, ACCESS, WAIT, RESP)
  - default AW=5 and DW=32 constants
  - requester index constants REQ0/REQ1
- One natural sub-module, rr_arb2: a 2-way round-robin picker. Inputs are req[1:0] and an update strobe; output is a one-hot grant. It contains the pointer register and the fixed-priority bypass under the macro.

Test Plan:
- Reset: hold rst, then release. All outputs read 0, busy=0. Assert rst again mid-run: outputs return to 0 asynchronously.
- Write: r0 writes addr 3, data 0xDEADBEEF.
  - mem_MemWrite=1 for exactly one cycle with mem_addr=3.
  - r0_ack appears 3 cycles after req is sampled; r1_ack stays 0.
- Read-back: r1 reads addr 3. r1_rdata=0xDEADBEEF with r1_ack; r0_rdata unchanged.
- Contention:
  - r0 and r1 both request at once: r0 is served first, then r1.
  - Repeat the tie: r1 is served first.
  - With MEM_ARB_FIXED_PRIO_EN defined: r0 is served first both times.
- Latency parameter, READ_LAT=2: read addr 0..3 after writing i to addr i. mem_MemRead is high 3 cycles; ack comes 5 cycles after req; rdata equals i.
- Reset during ACCESS of a write to addr 7 with data 0x55: mem_MemWrite drops at once, no ack, busy=0; a later read of addr 7 returns its prior value.
